// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one combinational add/sub datapath among N_REQ requesters.
// Optional FP_SCHED_STATS_EN adds stat_ops (response count) and stat_stall (saturating stall count).
module fp_add_scheduler #(
  parameter int N_REQ  = 4,
  parameter int W      = 16,
  parameter int DP_LAT = 1,
  parameter int ID_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*W-1:0]    req_a,
  input  logic [N_REQ*W-1:0]    req_b,
  input  logic [N_REQ-1:0]      req_sub,
  output logic [W-1:0]          dp_a,
  output logic [W-1:0]          dp_b,
  output logic                  dp_sub,
  input  logic [W-1:0]          dp_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [W-1:0]          rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
`ifdef FP_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [15:0]           stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] tag_q, tag_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [W-1:0]    dp_a_q, dp_a_d;
  logic [W-1:0]    dp_b_q, dp_b_d;
  logic            dp_sub_q, dp_sub_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic [ID_W-1:0] gnt, gnt_hi, gnt_lo;
  logic            gnt_vld, hi_vld, lo_vld;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_sub;

  // Rotating priority as two fixed-order scans: first valid above the pointer,
  // otherwise the first valid at or below it (wrap-around).
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        if (ID_W'(i) > ptr_q) begin
          if (!hi_vld) begin
            gnt_hi = ID_W'(i);
            hi_vld = 1'b1;
          end
        end else if (!lo_vld) begin
          gnt_lo = ID_W'(i);
          lo_vld = 1'b1;
        end
      end
    end
    gnt     = hi_vld ? gnt_hi : gnt_lo;
    gnt_vld = hi_vld | lo_vld;

    sel_a     = '0;
    sel_b     = '0;
    sel_sub   = 1'b0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_sub = req_sub[i];
      end
      req_ready[i] = (state_q == IDLE) && gnt_vld && (ID_W'(i) == gnt);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    dp_a_d     = dp_a_q;
    dp_b_d     = dp_b_q;
    dp_sub_d   = dp_sub_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          dp_a_d   = sel_a;
          dp_b_d   = sel_b;
          dp_sub_d = sel_sub;
          tag_d    = gnt;
          ptr_d    = gnt;
          cnt_d    = 4'(DP_LAT - 1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          rsp_data_d = dp_p;
          rsp_id_d   = tag_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= ID_W'(N_REQ - 1);
      tag_q      <= '0;
      cnt_q      <= '0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_sub_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      dp_sub_q   <= dp_sub_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_sub    = dp_sub_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

`ifdef FP_SCHED_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (state_q == RESP) begin
      if (rsp_ready) stat_ops_d = stat_ops_q + 32'd1;
      else if (stat_stall_q != '1) stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
